// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter: start, 5-8 data bits LSB-first, optional parity, 1-2 stop bits.
// Optional parity slot compiled in with `define UART_TX_PARITY_EN (PARITY_MODE: 0 none, 1 odd, 2 even).
module uart_tx_frame #(
    parameter int CLK_DIV     = 5208,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BPS_MAX = CW'(CLK_DIV - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          bps_cnt, bps_n;
    logic [2:0]             bit_cnt, bit_n;
    logic [DATA_BITS-1:0]   shift, shift_n;
    logic [DATA_BITS-1:0]   hold_data;
    logic                   hold_full, hold_full_n;
    logic                   tx_n;
    logic                   bit_end;
    logic                   load;
    logic                   accept;
`ifdef UART_TX_PARITY_EN
    logic                   par_bit, par_n;
`endif

    initial begin
        if (CLK_DIV < 2)                        $error("uart_tx_frame: CLK_DIV must be >= 2");
        if (DATA_BITS < 5 || DATA_BITS > 8)     $error("uart_tx_frame: DATA_BITS must be 5..8");
        if (STOP_BITS < 1 || STOP_BITS > 2)     $error("uart_tx_frame: STOP_BITS must be 1 or 2");
        if (PARITY_MODE < 0 || PARITY_MODE > 2) $error("uart_tx_frame: PARITY_MODE must be 0..2");
    end

    assign tx_ready = !hold_full;
    assign busy     = (state != IDLE) || hold_full;
    assign accept   = tx_valid && tx_ready;
    assign bit_end  = (bps_cnt == BPS_MAX);

    always_comb begin
        state_n = state;
        bps_n   = (state == IDLE || bit_end) ? '0 : bps_cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift;
        load    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_bit;
`endif
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    bit_n   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_n   = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = (PARITY_MODE != 0) ? PARITY : STOP;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        shift_n = shift >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_n = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_n = '0;
                        // Chain straight into the next start bit so frames abut with no idle gap.
                        if (hold_full) begin
                            load    = 1'b1;
                            state_n = START;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            shift_n = hold_data;
`ifdef UART_TX_PARITY_EN
            par_n   = (PARITY_MODE == 1) ? ~^hold_data : ^hold_data;
`endif
        end

        hold_full_n = load ? 1'b0 : (accept ? 1'b1 : hold_full);

        // The line is registered, so it is derived from where the FSM goes next.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bps_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            bps_cnt   <= bps_n;
            bit_cnt   <= bit_n;
            shift     <= shift_n;
            hold_full <= hold_full_n;
            tx        <= tx_n;
`ifdef UART_TX_PARITY_EN
            par_bit   <= par_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) hold_data <= tx_data;
    end

endmodule
